// File: rtl/mc14500_pc_sequencer.sv
// Program-flow sequencer for the cascaded MC14516B program counter of an MC14500B system.
// Turns ICU JMP/RTN flags into counter preset/hold controls and keeps a small return-address stack.
module mc14500_pc_sequencer #(
    parameter  int ADDR_W      = 8,
    parameter  int STACK_DEPTH = 4,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               jmp,
    input  logic               rtn,
    input  logic               call,
    input  logic [ADDR_W-1:0]  jmp_addr,
    input  logic               halt,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_reset,
    output logic               pc_preset_enable,
    output logic [ADDR_W-1:0]  pc_preset,
    output logic               pc_up_down,
    output logic               pc_carry_in,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow,
    output logic               underflow
);

    // state   | meaning
    // ST_RUN  | counter advances, jmp/rtn accepted
    // ST_LOAD | one-cycle counter preset, fetched instruction squashed
    // ST_HALT | counter frozen until halt drops
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] stack [0:STACK_DEPTH-1];
    logic [ADDR_W-1:0] preset_next;
    logic [ADDR_W-1:0] ret_addr;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic              push_en;
    logic              pop_en;
    logic              uf_set;

    assign pc_up_down = 1'b1;
    assign ret_addr   = pc + ADDR_W'(1);
    assign push_idx   = IDX_W'(depth);
    assign pop_idx    = IDX_W'(depth - DEPTH_ONE);

    always_comb begin
        state_next  = state;
        preset_next = pc_preset;
        push_en     = 1'b0;
        pop_en      = 1'b0;
        uf_set      = 1'b0;
        case (state)
            ST_RUN: begin
                // halt outranks jmp, jmp outranks rtn
                if (halt) begin
                    state_next = ST_HALT;
                end else if (jmp) begin
                    state_next  = ST_LOAD;
                    preset_next = jmp_addr;
                    push_en     = call;
                end else if (rtn) begin
                    if (depth != '0) begin
                        state_next  = ST_LOAD;
                        preset_next = stack[pop_idx];
                        pop_en      = 1'b1;
                    end else begin
                        uf_set = 1'b1;
                    end
                end
            end
            ST_LOAD: state_next = halt ? ST_HALT : ST_RUN;
            ST_HALT: if (!halt) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= ST_RUN;
            pc_reset         <= 1'b1;
            pc_preset_enable <= 1'b0;
            pc_preset        <= '0;
            pc_carry_in      <= 1'b1;
            depth            <= '0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            state            <= state_next;
            pc_reset         <= 1'b0;
            pc_preset_enable <= (state_next == ST_LOAD);
            pc_carry_in      <= (state_next != ST_RUN);
            pc_preset        <= preset_next;
            if (push_en) begin
                // a push into a full stack drops the entry but the jump still goes
                if (depth == DEPTH_FULL) begin
                    overflow <= 1'b1;
                end else begin
                    stack[push_idx] <= ret_addr;
                    depth           <= depth + DEPTH_ONE;
                end
            end
            if (pop_en) begin
                depth <= depth - DEPTH_ONE;
            end
            if (uf_set) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
